input_buffer_mc: RTL and testbench

- Next-generation trace input buffer: a circular vector queue with count-based full/empty that can use every entry.
- Arbitrary (non-power-of-2) depth, downstream valid/ready backpressure, and run-time chain-count configuration.
- Replays each dequeued vector once per active chain, with frame (bof/eof) tagging, overflow drop accounting and occupancy reporting.
- Sits between the trace tap and the first processing stage of the debug pipeline.

---
 rtl/input_buffer_mc.sv | 127 ++++++++++++
 tb/tb_input_buffer_mc.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_mc.sv
// Circular trace input buffer with count-based full/empty, per-chain replay of each
// dequeued vector, frame tagging, saturating drop accounting and occupancy reporting.
module input_buffer_mc #(
    parameter int unsigned N                = 8,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned IB_DEPTH         = 4,
    parameter int unsigned MAX_CHAINS       = 4,
    parameter int unsigned INITIAL_FIRMWARE = 1,
    parameter int unsigned CONFIG_ID        = 1,
    parameter int unsigned DROP_CNT_WIDTH   = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enqueue,
    input  logic                                eof_in,
    input  logic                                tracing,
    input  logic [7:0]                          configId,
    input  logic [7:0]                          configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]        vector_in,
    input  logic                                ready_in,
    output logic                                valid_out,
    output logic [N-1:0][DATA_WIDTH-1:0]        vector_out,
    output logic                                eof_out,
    output logic                                bof_out,
    output logic [$clog2(MAX_CHAINS)-1:0]       chainId_out,
    output logic [$clog2(IB_DEPTH+1)-1:0]       occupancy,
    output logic                                full,
    output logic                                empty,
    output logic [DROP_CNT_WIDTH-1:0]           drop_count
);

    localparam int unsigned PW = $clog2(IB_DEPTH);
    localparam int unsigned OW = $clog2(IB_DEPTH + 1);
    localparam int unsigned AW = $clog2(MAX_CHAINS + 1);

    localparam logic [7:0]    MaxCh8 = 8'(MAX_CHAINS);
    localparam logic [AW-1:0] InitAc = AW'(INITIAL_FIRMWARE);
    localparam logic [PW-1:0] LastPtr = PW'(IB_DEPTH - 1);

    logic [N-1:0][DATA_WIDTH-1:0] mem [IB_DEPTH];
    logic                         mem_eof [IB_DEPTH];

    logic [PW-1:0] head_q, tail_q;
    logic [OW-1:0] occ_q;
    logic [AW-1:0] ac_q, pend_ac_q, cfg_ac;
    logic          bof_pend_q;
    logic          last_beat, fire, can_load, pop, push, drop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + PW'(1);
    endfunction

    assign occupancy = occ_q;
    assign full      = (occ_q == OW'(IB_DEPTH));
    assign empty     = (occ_q == '0);

    always_comb begin
        last_beat = ((AW'(chainId_out) + AW'(1)) == ac_q);
        fire      = valid_out & ready_in;
        // Output stage takes a new vector when idle or when its final chain beat leaves.
        can_load  = !valid_out | (fire & last_beat);
        pop       = can_load & !empty;
        push      = enqueue & tracing & (!full | pop);
        drop      = enqueue & tracing & full & !pop;

        if (configData == 8'd0) begin
            cfg_ac = AW'(1);
        end else if (configData > MaxCh8) begin
            cfg_ac = AW'(MAX_CHAINS);
        end else begin
            cfg_ac = AW'(configData);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q]     <= vector_in;
            mem_eof[tail_q] <= eof_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            drop_count  <= '0;
            ac_q        <= InitAc;
            pend_ac_q   <= InitAc;
            bof_pend_q  <= 1'b1;
            valid_out   <= 1'b0;
            vector_out  <= '0;
            eof_out     <= 1'b0;
            bof_out     <= 1'b0;
            chainId_out <= '0;
        end else begin
            if (push) tail_q <= nxt(tail_q);
            if (pop)  head_q <= nxt(head_q);

            if (push && !pop) begin
                occ_q <= occ_q + OW'(1);
            end else if (pop && !push) begin
                occ_q <= occ_q - OW'(1);
            end

            if (drop && (drop_count != '1)) drop_count <= drop_count + DROP_CNT_WIDTH'(1);

            if (configId == 8'(CONFIG_ID)) pend_ac_q <= cfg_ac;

            if (pop) begin
                valid_out   <= 1'b1;
                vector_out  <= mem[head_q];
                eof_out     <= mem_eof[head_q];
                bof_out     <= bof_pend_q;
                bof_pend_q  <= mem_eof[head_q];
                chainId_out <= '0;
                ac_q        <= pend_ac_q;
            end else if (can_load) begin
                valid_out <= 1'b0;
            end else if (fire) begin
                chainId_out <= chainId_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_input_buffer_mc.sv
// Directed bench for input_buffer_mc: replay, backpressure, overflow, configuration, reset.
module tb_input_buffer_mc;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 32;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enqueue = 1'b0, eof_in = 1'b0, tracing = 1'b1, ready_in = 1'b1;
    logic [7:0] configId = 8'd0, configData = 8'd0;
    vec_t       vector_in = '0;
    logic       valid_out, eof_out, bof_out, full, empty;
    vec_t       vector_out;
    logic [1:0] chainId_out;
    logic [1:0] occupancy;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    input_buffer_mc #(
        .N(N), .DATA_WIDTH(DW), .IB_DEPTH(3), .MAX_CHAINS(4), .INITIAL_FIRMWARE(1),
        .CONFIG_ID(1), .DROP_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .enqueue(enqueue), .eof_in(eof_in), .tracing(tracing),
        .configId(configId), .configData(configData), .vector_in(vector_in),
        .ready_in(ready_in), .valid_out(valid_out), .vector_out(vector_out),
        .eof_out(eof_out), .bof_out(bof_out), .chainId_out(chainId_out),
        .occupancy(occupancy), .full(full), .empty(empty), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic [7:0] tag);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = {tag, 8'(i), 16'h5A3C};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input vec_t v, input logic e);
        enqueue = 1'b1; vector_in = v; eof_in = e;
    endtask

    task automatic configure(input logic [7:0] d);
        configId = 8'd1; configData = d;
        step();
        configId = 8'd0; configData = 8'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_cmp++;
        if ({valid_out, chainId_out, bof_out, eof_out} !== 5'b0 || vector_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got st=%b vec=%h, want st=00000 vec=0",
                     {valid_out, chainId_out, bof_out, eof_out}, vector_out);
        end
        n_cmp++;
        if ({occupancy, full, empty, drop_count} !== {2'd0, 1'b0, 1'b1, 16'd0}) begin
            n_bad++;
            $display("FAIL reset_status: got occ=%0d full=%b empty=%b drop=%0d, want 0 0 1 0",
                     occupancy, full, empty, drop_count);
        end
    endtask

    task automatic test_basic();
        vec_t v [3];
        logic [4:0] st [3];
        v[0] = mkv(8'h0A); v[1] = mkv(8'h0B); v[2] = mkv(8'h0C);
        st[0] = 5'b1_00_1_0; st[1] = 5'b1_00_0_1; st[2] = 5'b1_00_1_0;
        push(v[0], 1'b0); step();
        push(v[1], 1'b1); step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({valid_out, chainId_out, bof_out, eof_out} !== st[i] || vector_out !== v[i]) begin
                n_bad++;
                $display("FAIL basic_beat%0d: got st=%b vec=%h, want st=%b vec=%h", i,
                         {valid_out, chainId_out, bof_out, eof_out}, vector_out, st[i], v[i]);
            end
            if (i == 0) push(v[2], 1'b0);
            else enqueue = 1'b0;
            step();
        end
        n_cmp++;
        if (valid_out !== 1'b0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_drain: got valid=%b empty=%b, want 0 1", valid_out, empty);
        end
    endtask

    task automatic test_config_replay();
        vec_t x;
        x = mkv(8'h58);
        configure(8'd3);
        push(x, 1'b0); step();
        enqueue = 1'b0; step();
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({valid_out, chainId_out, bof_out, eof_out} !== {1'b1, 2'(c), 2'b00} ||
                vector_out !== x) begin
                n_bad++;
                $display("FAIL replay3_chain%0d: got st=%b vec=%h, want st=%b vec=%h", c,
                         {valid_out, chainId_out, bof_out, eof_out}, vector_out,
                         {1'b1, 2'(c), 2'b00}, x);
            end
            step();
        end
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL replay3_end: got valid=%b, want 0", valid_out);
        end
    endtask

    task automatic test_stall();
        vec_t y;
        y = mkv(8'h59);
        push(y, 1'b0); step();
        enqueue = 1'b0; step(); step();
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if ({valid_out, chainId_out} !== 3'b1_01 || vector_out !== y) begin
                n_bad++;
                $display("FAIL stall_hold%0d: got v=%b ch=%0d vec=%h, want v=1 ch=1 vec=%h", k,
                         valid_out, chainId_out, vector_out, y);
            end
        end
        ready_in = 1'b1;
        step();
        n_cmp++;
        if ({valid_out, chainId_out} !== 3'b1_10 || vector_out !== y) begin
            n_bad++;
            $display("FAIL stall_resume: got v=%b ch=%0d, want v=1 ch=2", valid_out, chainId_out);
        end
        step();
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_end: got valid=%b, want 0", valid_out);
        end
    endtask

    task automatic test_config_midreplay();
        vec_t v1, v2, w;
        v1 = mkv(8'h71); v2 = mkv(8'h72); w = mkv(8'h77);
        configure(8'd4);
        push(v1, 1'b0); step();
        push(v2, 1'b0); step();
        enqueue = 1'b0; configId = 8'd1; configData = 8'd2;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if ({valid_out, chainId_out} !== {1'b1, 2'(c)} || vector_out !== v1) begin
                n_bad++;
                $display("FAIL mid_v1_chain%0d: got v=%b ch=%0d vec=%h, want v=1 ch=%0d vec=%h",
                         c, valid_out, chainId_out, vector_out, c, v1);
            end
            step();
            configId = 8'd0;
        end
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if ({valid_out, chainId_out} !== {1'b1, 2'(c)} || vector_out !== v2) begin
                n_bad++;
                $display("FAIL mid_v2_chain%0d: got v=%b ch=%0d vec=%h, want v=1 ch=%0d vec=%h",
                         c, valid_out, chainId_out, vector_out, c, v2);
            end
            step();
        end
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_v2_end: got valid=%b, want 0", valid_out);
        end
        // configData 0 clamps to one chain, 9 clamps to four.
        configure(8'd0);
        push(w, 1'b0); step();
        enqueue = 1'b0; step(); step();
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL clamp0: got valid=%b after one beat, want 0", valid_out);
        end
        configure(8'd9);
        push(w, 1'b0); step();
        enqueue = 1'b0; step();
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if ({valid_out, chainId_out} !== {1'b1, 2'(c)}) begin
                n_bad++;
                $display("FAIL clamp9_chain%0d: got v=%b ch=%0d, want v=1 ch=%0d", c,
                         valid_out, chainId_out, c);
            end
            step();
        end
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL clamp9_end: got valid=%b, want 0", valid_out);
        end
    endtask

    task automatic test_overflow();
        vec_t v [7];
        vec_t expv [5];
        logic [1:0] expocc [5];
        for (int i = 0; i < 7; i++) v[i] = mkv(8'h90 + 8'(i));
        configure(8'd1);
        ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(v[i], 1'b0); step();
        end
        n_cmp++;
        if ({occupancy, full, drop_count} !== {2'd3, 1'b1, 16'd2} || vector_out !== v[0]) begin
            n_bad++;
            $display("FAIL overflow_full: got occ=%0d full=%b drop=%0d, want occ=3 full=1 drop=2",
                     occupancy, full, drop_count);
        end
        tracing = 1'b0;
        push(v[6], 1'b0); step();
        tracing = 1'b1;
        n_cmp++;
        if ({occupancy, drop_count} !== {2'd3, 16'd2}) begin
            n_bad++;
            $display("FAIL overflow_notrace: got occ=%0d drop=%0d, want occ=3 drop=2",
                     occupancy, drop_count);
        end
        // Push and pop together at full: accepted, no drop.
        ready_in = 1'b1;
        push(v[6], 1'b0);
        expv[0] = v[1]; expv[1] = v[2]; expv[2] = v[3]; expv[3] = v[6];
        expocc[0] = 2'd3; expocc[1] = 2'd2; expocc[2] = 2'd1; expocc[3] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            enqueue = 1'b0;
            n_cmp++;
            if (valid_out !== 1'b1 || vector_out !== expv[i] || occupancy !== expocc[i] ||
                drop_count !== 16'd2) begin
                n_bad++;
                $display("FAIL overflow_drain%0d: got v=%b occ=%0d drop=%0d vec=%h, want v=1 occ=%0d drop=2 vec=%h",
                         i, valid_out, occupancy, drop_count, vector_out, expocc[i], expv[i]);
            end
        end
        step();
        n_cmp++;
        if (valid_out !== 1'b0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_end: got valid=%b empty=%b, want 0 1", valid_out, empty);
        end
    endtask

    task automatic test_reset_midreplay();
        vec_t r;
        r = mkv(8'hEE);
        configure(8'd4);
        push(mkv(8'hA1), 1'b0); step();
        push(mkv(8'hA2), 1'b0); step();
        push(mkv(8'hA3), 1'b0); step();
        enqueue = 1'b0;
        n_cmp++;
        if ({valid_out, chainId_out, occupancy} !== {1'b1, 2'd1, 2'd2}) begin
            n_bad++;
            $display("FAIL prereset: got v=%b ch=%0d occ=%0d, want v=1 ch=1 occ=2",
                     valid_out, chainId_out, occupancy);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({valid_out, chainId_out, bof_out, eof_out, occupancy, empty} !== {5'b0, 2'd0, 1'b1} ||
            vector_out !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b ch=%0d occ=%0d empty=%b vec=%h, want all 0, empty=1",
                     valid_out, chainId_out, occupancy, empty, vector_out);
        end
        step();
        reset = 1'b0;
        push(r, 1'b1); step();
        enqueue = 1'b0; step();
        n_cmp++;
        if ({valid_out, chainId_out, bof_out, eof_out} !== 5'b1_00_1_1 || vector_out !== r) begin
            n_bad++;
            $display("FAIL post_reset_bof: got st=%b vec=%h, want st=10011 vec=%h",
                     {valid_out, chainId_out, bof_out, eof_out}, vector_out, r);
        end
        step();
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_ac: got valid=%b, want 0", valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_config_replay();
        test_stall();
        test_config_midreplay();
        test_overflow();
        test_reset_midreplay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, want finish before timeout");
        $fatal(1, "timeout");
    end

endmodule
